// File: rtl/bsg_thermometer_credit_counter_pkg.sv
// Shared types for the thermometer credit counter and its shift/fill datapath.
package bsg_thermometer_credit_counter_pkg;

  typedef enum logic {
    shift_up   = 1'b0,
    shift_down = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/bsg_thermometer_shift_fill.sv
// Combinational thermometer shifter: up-shift fills ones at the LSB and saturates,
// down-shift fills zeros at the MSB.
module bsg_thermometer_shift_fill
  import bsg_thermometer_credit_counter_pkg::*;
#(
  parameter int unsigned width_p     = 32,
  parameter int unsigned max_shift_p = 4,
  localparam int unsigned amt_width_lp = $clog2(max_shift_p + 1)
) (
  input  logic [width_p-1:0]      thermo,
  input  logic [amt_width_lp-1:0] amount,
  input  shift_dir_e              dir,
  output logic [width_p-1:0]      shifted,
  output logic                    overflow
);

  localparam logic [width_p-1:0] ones_lp = '1;

  logic [width_p-1:0] up_fill;
  logic [31:0]        spill_shift;

  // Any set bit in the top 'amount' positions means count + amount exceeds width_p.
  always_comb begin
    spill_shift = 32'(width_p) - 32'(amount);
    up_fill     = (thermo << amount) | ~(ones_lp << amount);
    shifted     = thermo;
    overflow    = 1'b0;
    if (dir == shift_up) begin
      overflow = |(thermo >> spill_shift);
      shifted  = overflow ? ones_lp : up_fill;
    end else begin
      shifted  = thermo >> amount;
    end
  end

endmodule

// File: rtl/bsg_thermometer_credit_counter.sv
// Link credit tracker holding its credit count as a thermometer code so that
// ready/threshold tests are single-bit reads of the state register.
module bsg_thermometer_credit_counter
  import bsg_thermometer_credit_counter_pkg::*;
#(
  parameter int unsigned width_p      = 32,
  parameter int unsigned max_return_p = 4,
  parameter int unsigned init_full_p  = 1,
  parameter int unsigned thresh_p     = 8,
  localparam int unsigned ret_width_lp = $clog2(max_return_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    send_v_i,
  output logic                    send_ready_o,
  input  logic [ret_width_lp-1:0] ret_i,
  input  logic                    clear_err_i,
  output logic [width_p-1:0]      thermo_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    low_o,
  output logic                    overflow_o
);

  localparam logic [width_p-1:0]      init_lp    = (init_full_p != 0) ? '1 : '0;
  localparam logic [ret_width_lp-1:0] max_ret_lp = ret_width_lp'(max_return_p);

  logic [width_p-1:0]      thermo_r;
  logic [width_p-1:0]      thermo_n;
  logic                    overflow_r;
  logic                    overflow_n;
  logic                    accept;
  logic [ret_width_lp-1:0] ret_clamped;
  logic [ret_width_lp-1:0] amount;
  shift_dir_e              dir;
  logic                    shift_ovf;

  assign accept = send_v_i & thermo_r[0];

  // Net change is ret - accept: a lone accept shifts down by one, otherwise shift up.
  always_comb begin
    ret_clamped = (ret_i > max_ret_lp) ? max_ret_lp : ret_i;
    dir         = shift_up;
    amount      = ret_clamped;
    if (accept) begin
      if (ret_clamped == '0) begin
        dir    = shift_down;
        amount = ret_width_lp'(1);
      end else begin
        amount = ret_clamped - ret_width_lp'(1);
      end
    end
  end

  bsg_thermometer_shift_fill #(
    .width_p     (width_p),
    .max_shift_p (max_return_p)
  ) shift_fill (
    .thermo   (thermo_r),
    .amount   (amount),
    .dir      (dir),
    .shifted  (thermo_n),
    .overflow (shift_ovf)
  );

  // A new overflow takes priority over a same-cycle clear.
  assign overflow_n = shift_ovf | (overflow_r & ~clear_err_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      thermo_r   <= init_lp;
      overflow_r <= 1'b0;
    end else begin
      thermo_r   <= thermo_n;
      overflow_r <= overflow_n;
    end
  end

  assign thermo_o     = thermo_r;
  assign send_ready_o = thermo_r[0];
  assign empty_o      = ~thermo_r[0];
  assign full_o       = thermo_r[width_p-1];
  assign low_o        = ~thermo_r[thresh_p-1];
  assign overflow_o   = overflow_r;

  ret_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i) ret_i <= max_ret_lp)
    else $error("ret_i exceeds max_return_p");

  thermo_legal_a: assert property (@(posedge clk_i) (thermo_r & (thermo_r + width_p'(1))) == '0)
    else $error("thermo_r is not a thermometer code");

endmodule

// File: tb/tb_bsg_thermometer_credit_counter.sv
// Scoreboard bench for bsg_thermometer_credit_counter (32 credits, 4 returns/cycle, full at reset).
module tb_bsg_thermometer_credit_counter;

  localparam int unsigned W  = 32;
  localparam int unsigned R  = 4;
  localparam int unsigned T  = 8;
  localparam int unsigned RW = 3;

  logic          clk_i;
  logic          reset_i;
  logic          send_v_i;
  logic          send_ready_o;
  logic [RW-1:0] ret_i;
  logic          clear_err_i;
  logic [W-1:0]  thermo_o;
  logic          empty_o;
  logic          full_o;
  logic          low_o;
  logic          overflow_o;

  bsg_thermometer_credit_counter #(
    .width_p      (W),
    .max_return_p (R),
    .init_full_p  (1),
    .thresh_p     (T)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .send_v_i     (send_v_i),
    .send_ready_o (send_ready_o),
    .ret_i        (ret_i),
    .clear_err_i  (clear_err_i),
    .thermo_o     (thermo_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .low_o        (low_o),
    .overflow_o   (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          send;
    logic [RW-1:0] ret;
    logic          clr;
    int            cnt;
    logic          ovf;
  } vec_t;

  int          compared;
  int          mismatched;
  int          m_cnt;
  logic        m_ovf;
  logic [36:0] sb[$];
  string       tag;
  vec_t        vecs[16];

  function automatic logic [W-1:0] thermo_of(input int c);
    logic [W-1:0] t;
    t = '0;
    for (int i = 0; i < int'(W); i++) if (i < c) t[i] = 1'b1;
    return t;
  endfunction

  function automatic logic [36:0] pack_exp(input int c, input logic o);
    return {thermo_of(c), c > 0, c == 0, c == int'(W), c < int'(T), o};
  endfunction

  function automatic logic [36:0] pack_act();
    return {thermo_o, send_ready_o, empty_o, full_o, low_o, overflow_o};
  endfunction

  task automatic compare(input string name, input logic [36:0] act, input logic [36:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got thermo=%h rdy/emp/full/low/ovf=%b, expected thermo=%h rdy/emp/full/low/ovf=%b",
               name, act[36:5], act[4:0], exp[36:5], exp[4:0]);
    end
  endtask

  task automatic check_pop();
    logic [36:0] exp;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: scoreboard empty at sample time", tag);
    end else begin
      exp = sb.pop_front();
      compare(tag, pack_act(), exp);
    end
  endtask

  // Drive one cycle of stimulus with its expected post-edge result, then sample after the edge.
  task automatic drive(input logic s, input logic [RW-1:0] r, input logic c,
                       input int ec, input logic eo);
    send_v_i    = s;
    ret_i       = r;
    clear_err_i = c;
    sb.push_back(pack_exp(ec, eo));
    m_cnt = ec;
    m_ovf = eo;
    @(posedge clk_i);
    #1;
    send_v_i    = 1'b0;
    ret_i       = '0;
    clear_err_i = 1'b0;
    check_pop();
  endtask

  // Reference model: arithmetic credit count with saturation and sticky overflow.
  task automatic step(input logic s, input logic [RW-1:0] r, input logic c);
    int acc;
    int sum;
    acc = (s && m_cnt > 0) ? 1 : 0;
    sum = m_cnt + int'(r) - acc;
    drive(s, r, c, (sum > int'(W)) ? int'(W) : sum, (sum > int'(W)) || (m_ovf && !c));
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    send_v_i    = 1'b0;
    ret_i       = '0;
    clear_err_i = 1'b0;
    reset_i     = 1'b0;

    vecs[0]  = '{1'b0, 3'd3, 1'b0,  3, 1'b0};
    vecs[1]  = '{1'b1, 3'd1, 1'b0,  3, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 1'b0,  3, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 1'b0,  3, 1'b0};
    vecs[4]  = '{1'b0, 3'd4, 1'b0,  7, 1'b0};
    vecs[5]  = '{1'b0, 3'd4, 1'b0, 11, 1'b0};
    vecs[6]  = '{1'b0, 3'd4, 1'b0, 15, 1'b0};
    vecs[7]  = '{1'b0, 3'd4, 1'b0, 19, 1'b0};
    vecs[8]  = '{1'b0, 3'd4, 1'b0, 23, 1'b0};
    vecs[9]  = '{1'b0, 3'd4, 1'b0, 27, 1'b0};
    vecs[10] = '{1'b0, 3'd3, 1'b0, 30, 1'b0};
    vecs[11] = '{1'b0, 3'd4, 1'b0, 32, 1'b1};
    vecs[12] = '{1'b0, 3'd4, 1'b1, 32, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 1'b1, 32, 1'b0};
    vecs[14] = '{1'b1, 3'd0, 1'b0, 31, 1'b0};
    vecs[15] = '{1'b0, 3'd1, 1'b0, 32, 1'b0};

    #1 reset_i = 1'b1;
    #1 compare("reset_state", pack_act(), pack_exp(32, 1'b0));
    @(posedge clk_i);
    #3 reset_i = 1'b0;
    m_cnt = 32;
    m_ovf = 1'b0;

    tag = "drain";
    for (int i = 0; i < 32; i++) step(1'b1, 3'd0, 1'b0);
    tag = "send_when_empty";
    step(1'b1, 3'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].send, vecs[i].ret, vecs[i].clr, vecs[i].cnt, vecs[i].ovf);
    end

    tag = "to_low";
    for (int i = 0; i < 25; i++) step(1'b1, 3'd0, 1'b0);
    tag = "low_exit";
    step(1'b0, 3'd1, 1'b0);
    tag = "low_enter";
    step(1'b1, 3'd0, 1'b0);

    tag = "to_five";
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    send_v_i = 1'b1;
    #3 reset_i = 1'b1;
    #1 compare("async_reset", pack_act(), pack_exp(32, 1'b0));
    @(posedge clk_i);
    #1;
    send_v_i = 1'b0;
    reset_i  = 1'b0;
    compare("reset_drops_accept", pack_act(), pack_exp(32, 1'b0));
    m_cnt = 32;
    m_ovf = 1'b0;
    tag = "post_reset_accept";
    step(1'b1, 3'd0, 1'b0);

    tag = "random";
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(1)), RW'($urandom_range(R)), ($urandom_range(15) == 0));

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
